// File: rtl/alu_issue_ctrl.sv
// Issue/decode controller for the 32-bit MIPS ALU: accepts one ALU instruction,
// iterates 1-bit shifts, and presents a masked writeback record.
module alu_issue_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] instr,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  output logic [4:0]  alu_fs,
  output logic [31:0] alu_s,
  output logic [31:0] alu_t,
  input  logic        alu_n,
  input  logic        alu_z,
  input  logic        alu_v,
  input  logic        alu_c,
  input  logic [31:0] alu_y_lo,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] wb_data,
  output logic [4:0]  wb_reg,
  output logic        wb_en,
  output logic [3:0]  flags,
  output logic        illegal,
  output logic        ovf_trap
);

  localparam logic [4:0] FS_PASS_T = 5'h01, FS_ADD  = 5'h02, FS_SUB  = 5'h03,
                         FS_ADDU   = 5'h04, FS_SUBU = 5'h05, FS_SLT  = 5'h06,
                         FS_SLTU   = 5'h07, FS_AND  = 5'h08, FS_OR   = 5'h09,
                         FS_XOR    = 5'h0A, FS_NOR  = 5'h0B, FS_SLL  = 5'h0C,
                         FS_SRL    = 5'h0D, FS_SRA  = 5'h0E, FS_ZERO = 5'h13,
                         FS_ANDI   = 5'h16, FS_ORI  = 5'h17, FS_LUI  = 5'h18,
                         FS_XORI   = 5'h19;

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;
  state_t state, state_nxt;

  function automatic logic [3:0] mask_flags(input logic [4:0] fs, input logic [3:0] nzvc);
    logic arith, shift;
    arith = fs inside {FS_ADD, FS_SUB, FS_ADDU, FS_SUBU};
    shift = fs inside {FS_SLL, FS_SRL, FS_SRA};
    return {nzvc[3], nzvc[2], nzvc[1] & arith, nzvc[0] & (arith | shift)};
  endfunction

  logic [5:0]         opcode, funct;
  logic signed [31:0] imm_sx;
  logic [4:0]         dec_fs, dec_dest, dec_cnt;
  logic [31:0]        dec_t;
  logic               dec_shift, dec_illegal;

  assign opcode = instr[31:26];
  assign funct  = instr[5:0];
  assign imm_sx = {{16{instr[15]}}, instr[15:0]};

  always_comb begin
    dec_fs      = FS_ZERO;
    dec_dest    = instr[15:11];
    dec_t       = rt_data;
    dec_cnt     = 5'd0;
    dec_shift   = 1'b0;
    dec_illegal = 1'b0;
    if (opcode == 6'h00) begin
      case (funct)
        6'h20: dec_fs = FS_ADD;
        6'h21: dec_fs = FS_ADDU;
        6'h22: dec_fs = FS_SUB;
        6'h23: dec_fs = FS_SUBU;
        6'h24: dec_fs = FS_AND;
        6'h25: dec_fs = FS_OR;
        6'h26: dec_fs = FS_XOR;
        6'h27: dec_fs = FS_NOR;
        6'h2A: dec_fs = FS_SLT;
        6'h2B: dec_fs = FS_SLTU;
        6'h00, 6'h02, 6'h03: begin
          dec_shift = 1'b1;
          dec_cnt   = instr[10:6];
          // a zero shift amount still takes one EXEC cycle, passing T through
          if (instr[10:6] == 5'd0)   dec_fs = FS_PASS_T;
          else if (funct == 6'h00)   dec_fs = FS_SLL;
          else if (funct == 6'h02)   dec_fs = FS_SRL;
          else                       dec_fs = FS_SRA;
        end
        default: dec_illegal = 1'b1;
      endcase
    end else begin
      dec_dest = instr[20:16];
      case (opcode)
        6'h08: begin dec_fs = FS_ADD;  dec_t = imm_sx; end
        6'h09: begin dec_fs = FS_ADDU; dec_t = imm_sx; end
        6'h0A: begin dec_fs = FS_SLT;  dec_t = imm_sx; end
        6'h0B: begin dec_fs = FS_SLTU; dec_t = imm_sx; end
        6'h0C: begin dec_fs = FS_ANDI; dec_t = instr; end
        6'h0D: begin dec_fs = FS_ORI;  dec_t = instr; end
        6'h0E: begin dec_fs = FS_XORI; dec_t = instr; end
        6'h0F: begin dec_fs = FS_LUI;  dec_t = instr; end
        default: dec_illegal = 1'b1;
      endcase
    end
  end

  logic [31:0] s_p0, t_p0, y_p1;
  logic [4:0]  fs_p0, cnt_p0, dest_p0;
  logic        shift_p0, illegal_p0, accept, step;
  logic [3:0]  flg_p1;

  assign accept = in_ready & in_valid;
  assign step   = (state == EXEC) & shift_p0 & (cnt_p0 > 5'd1);

  // issue stage: operands latched on accept; T recirculates through the ALU while shifting
  always_ff @(posedge clk) begin
    if (accept) begin
      s_p0  <= rs_data;
      t_p0  <= dec_t;
      fs_p0 <= dec_fs;
    end else if (step) begin
      t_p0  <= alu_y_lo;
    end
  end

  // result stage: cleared on accept so illegal records report zero data and flags
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cnt_p0     <= 5'd0;
      shift_p0   <= 1'b0;
      dest_p0    <= 5'd0;
      illegal_p0 <= 1'b0;
      y_p1       <= '0;
      flg_p1     <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        cnt_p0     <= dec_cnt;
        shift_p0   <= dec_shift;
        dest_p0    <= dec_dest;
        illegal_p0 <= dec_illegal;
        y_p1       <= '0;
        flg_p1     <= '0;
      end else if (state == EXEC) begin
        y_p1   <= alu_y_lo;
        flg_p1 <= mask_flags(fs_p0, {alu_n, alu_z, alu_v, alu_c});
        if (step) cnt_p0 <= cnt_p0 - 5'd1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    alu_fs    = FS_ZERO;
    alu_s     = '0;
    alu_t     = '0;
    case (state)
      IDLE: begin
        in_ready = ~reset;
        if (in_valid) state_nxt = dec_illegal ? DONE : EXEC;
      end
      EXEC: begin
        alu_fs = fs_p0;
        alu_s  = s_p0;
        alu_t  = t_p0;
        if (!step) state_nxt = DONE;
      end
      DONE: begin
        out_valid = ~reset;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign wb_data  = y_p1;
  assign flags    = flg_p1;
  assign wb_reg   = dest_p0;
  assign illegal  = illegal_p0;
  assign ovf_trap = flg_p1[1] & ((fs_p0 == FS_ADD) | (fs_p0 == FS_SUB));
  assign wb_en    = (dest_p0 != 5'd0) & ~illegal_p0 & ~ovf_trap;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with a behavioural MIPS ALU on the far side.
module tb_alu_issue_ctrl;
  logic        clk = 1'b0;
  logic        reset, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] instr, rs_data, rt_data, alu_s, alu_t, alu_y_lo, wb_data;
  logic [4:0]  alu_fs, wb_reg;
  logic        alu_n, alu_z, alu_v, alu_c, wb_en, illegal, ovf_trap;
  logic [3:0]  flags;
  logic [32:0] sum;
  int          errors = 0, checks = 0;
  int          cyc;
  logic [4:0]  fs1;
  logic [31:0] held;
  logic        seen;

  always #5 clk = ~clk;

  alu_issue_ctrl dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .instr(instr), .rs_data(rs_data), .rt_data(rt_data),
    .alu_fs(alu_fs), .alu_s(alu_s), .alu_t(alu_t),
    .alu_n(alu_n), .alu_z(alu_z), .alu_v(alu_v), .alu_c(alu_c), .alu_y_lo(alu_y_lo),
    .out_valid(out_valid), .out_ready(out_ready), .wb_data(wb_data), .wb_reg(wb_reg),
    .wb_en(wb_en), .flags(flags), .illegal(illegal), .ovf_trap(ovf_trap)
  );

  // behavioural ALU: shifts move T by one bit, C = bit shifted out
  always_comb begin
    sum = '0; alu_y_lo = '0; alu_v = 1'b0; alu_c = 1'b0;
    case (alu_fs)
      5'h00: alu_y_lo = alu_s;
      5'h01: alu_y_lo = alu_t;
      5'h02, 5'h04: begin
        sum = {1'b0, alu_s} + {1'b0, alu_t};
        alu_y_lo = sum[31:0]; alu_c = sum[32];
        alu_v = (alu_s[31] == alu_t[31]) && (sum[31] != alu_s[31]);
      end
      5'h03, 5'h05: begin
        sum = {1'b0, alu_s} - {1'b0, alu_t};
        alu_y_lo = sum[31:0]; alu_c = sum[32];
        alu_v = (alu_s[31] != alu_t[31]) && (sum[31] != alu_s[31]);
      end
      5'h06: alu_y_lo = ($signed(alu_s) < $signed(alu_t)) ? 32'd1 : 32'd0;
      5'h07: alu_y_lo = (alu_s < alu_t) ? 32'd1 : 32'd0;
      5'h08: alu_y_lo = alu_s & alu_t;
      5'h09: alu_y_lo = alu_s | alu_t;
      5'h0A: alu_y_lo = alu_s ^ alu_t;
      5'h0B: alu_y_lo = ~(alu_s | alu_t);
      5'h0C: begin alu_y_lo = {alu_t[30:0], 1'b0}; alu_c = alu_t[31]; end
      5'h0D: begin alu_y_lo = {1'b0, alu_t[31:1]}; alu_c = alu_t[0]; end
      5'h0E: begin alu_y_lo = {alu_t[31], alu_t[31:1]}; alu_c = alu_t[0]; end
      5'h16: alu_y_lo = alu_s & {16'h0, alu_t[15:0]};
      5'h17: alu_y_lo = alu_s | {16'h0, alu_t[15:0]};
      5'h18: alu_y_lo = {alu_t[15:0], 16'h0};
      5'h19: alu_y_lo = alu_s ^ {16'h0, alu_t[15:0]};
      default: alu_y_lo = '0;
    endcase
    alu_n = alu_y_lo[31];
    alu_z = (alu_y_lo == 32'd0);
  end

  function automatic logic [31:0] r_ins(input logic [4:0] rs, rt, rd, sh, input logic [5:0] fn);
    return {6'h00, rs, rt, rd, sh, fn};
  endfunction

  function automatic logic [31:0] i_ins(input logic [5:0] op, input logic [4:0] rs, rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wait_rec(output int c, output logic [4:0] f1);
    c = 0; f1 = 5'h1F;
    while (c < 64) begin
      @(negedge clk); c++;
      if (c == 1) f1 = alu_fs;
      if (out_valid) break;
    end
  endtask

  task automatic run(input logic [31:0] ins, input logic [31:0] rs, input logic [31:0] rt,
                     output int c, output logic [4:0] f1);
    int k;
    @(negedge clk);
    instr = ins; rs_data = rs; rt_data = rt; in_valid = 1'b1;
    k = 0;
    while (!in_ready && k < 20) begin @(negedge clk); k++; end
    chk("hs_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1 in_valid = 1'b0;
    wait_rec(c, f1);
  endtask

  task automatic take;
    out_ready = 1'b1;
    @(posedge clk); #1 out_ready = 1'b0;
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    instr = '0; rs_data = '0; rt_data = '0;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_wb_data", wb_data, 32'd0);
    chk("rst_wb_reg", {27'd0, wb_reg}, 32'd0);
    chk("rst_wb_en", {31'd0, wb_en}, 32'd0);
    chk("rst_flags", {28'd0, flags}, 32'd0);
    chk("rst_illegal", {31'd0, illegal}, 32'd0);
    chk("rst_ovf", {31'd0, ovf_trap}, 32'd0);
    chk("rst_alu_fs", {27'd0, alu_fs}, 32'h13);
    chk("rst_alu_s", alu_s, 32'd0);
    chk("rst_alu_t", alu_t, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", {31'd0, in_ready}, 32'd1);

    // add with signed overflow
    run(r_ins(5'd1, 5'd2, 5'd3, 5'd0, 6'h20), 32'h7FFF_FFFF, 32'h0000_0001, cyc, fs1);
    chk("add_cyc", cyc, 32'd2);
    chk("add_fs", {27'd0, fs1}, 32'h02);
    chk("add_data", wb_data, 32'h8000_0000);
    chk("add_flags", {28'd0, flags}, 32'hA);
    chk("add_ovf", {31'd0, ovf_trap}, 32'd1);
    chk("add_wb_en", {31'd0, wb_en}, 32'd0);
    chk("add_wb_reg", {27'd0, wb_reg}, 32'd3);
    chk("add_ready_done", {31'd0, in_ready}, 32'd0);
    take();

    // sll by 4
    run(r_ins(5'd0, 5'd2, 5'd5, 5'd4, 6'h00), 32'h0, 32'h0000_000F, cyc, fs1);
    chk("sll4_cyc", cyc, 32'd5);
    chk("sll4_fs", {27'd0, fs1}, 32'h0C);
    chk("sll4_data", wb_data, 32'h0000_00F0);
    chk("sll4_wb_en", {31'd0, wb_en}, 32'd1);
    chk("sll4_flags", {28'd0, flags}, 32'h0);
    take();

    // sra by 31
    run(r_ins(5'd0, 5'd2, 5'd6, 5'd31, 6'h03), 32'h0, 32'h8000_0000, cyc, fs1);
    chk("sra31_cyc", cyc, 32'd32);
    chk("sra31_data", wb_data, 32'hFFFF_FFFF);
    chk("sra31_flags", {28'd0, flags}, 32'h8);
    take();

    // sll by 0 passes T
    run(r_ins(5'd0, 5'd2, 5'd7, 5'd0, 6'h00), 32'h0, 32'h1234_5678, cyc, fs1);
    chk("sll0_cyc", cyc, 32'd2);
    chk("sll0_fs", {27'd0, fs1}, 32'h01);
    chk("sll0_data", wb_data, 32'h1234_5678);
    take();

    // addi 5 + (-1)
    run(i_ins(6'h08, 5'd1, 5'd2, 16'hFFFF), 32'h0000_0005, 32'h0, cyc, fs1);
    chk("addi_data", wb_data, 32'h0000_0004);
    chk("addi_flags", {28'd0, flags}, 32'h1);
    chk("addi_ovf", {31'd0, ovf_trap}, 32'd0);
    chk("addi_wb_reg", {27'd0, wb_reg}, 32'd2);
    chk("addi_wb_en", {31'd0, wb_en}, 32'd1);
    take();

    run(i_ins(6'h0F, 5'd0, 5'd4, 16'h1234), 32'h0, 32'h0, cyc, fs1);
    chk("lui_data", wb_data, 32'h1234_0000);
    take();

    run(i_ins(6'h0C, 5'd1, 5'd8, 16'h00F0), 32'hFFFF_FFFF, 32'h0, cyc, fs1);
    chk("andi_data", wb_data, 32'h0000_00F0);
    chk("andi_flags", {28'd0, flags}, 32'h0);
    take();

    run(i_ins(6'h0B, 5'd1, 5'd9, 16'hFFFF), 32'h0000_0001, 32'h0, cyc, fs1);
    chk("sltiu_data", wb_data, 32'h0000_0001);
    take();

    // lw is not an ALU instruction
    run(i_ins(6'h23, 5'd1, 5'd9, 16'h0004), 32'h1111_1111, 32'h2222_2222, cyc, fs1);
    chk("lw_cyc", cyc, 32'd1);
    chk("lw_illegal", {31'd0, illegal}, 32'd1);
    chk("lw_wb_en", {31'd0, wb_en}, 32'd0);
    chk("lw_data", wb_data, 32'd0);
    chk("lw_flags", {28'd0, flags}, 32'h0);
    take();

    run(r_ins(5'd1, 5'd2, 5'd0, 5'd0, 6'h25), 32'h0000_00F0, 32'h0000_000F, cyc, fs1);
    chk("or0_data", wb_data, 32'h0000_00FF);
    chk("or0_wb_en", {31'd0, wb_en}, 32'd0);
    chk("or0_illegal", {31'd0, illegal}, 32'd0);
    take();

    // back-pressure: record held while a new instruction waits
    run(r_ins(5'd1, 5'd2, 5'd11, 5'd0, 6'h24), 32'hFF00_FF00, 32'h0FF0_0FF0, cyc, fs1);
    chk("bp_data", wb_data, 32'h0F00_0F00);
    held = wb_data;
    instr = r_ins(5'd1, 5'd2, 5'd10, 5'd0, 6'h26); in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_valid", {31'd0, out_valid}, 32'd1);
      chk("bp_ready", {31'd0, in_ready}, 32'd0);
      chk("bp_hold", wb_data, held);
      chk("bp_reg", {27'd0, wb_reg}, 32'd11);
    end
    take();
    @(negedge clk);
    chk("bp_idle_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1 in_valid = 1'b0;
    wait_rec(cyc, fs1);
    chk("bp_next_cyc", cyc, 32'd2);
    chk("bp_next_data", wb_data, 32'hF0F0_F0F0);
    chk("bp_next_reg", {27'd0, wb_reg}, 32'd10);
    take();

    // reset during a long shift
    @(negedge clk);
    instr = r_ins(5'd0, 5'd2, 5'd5, 5'd10, 6'h00); rt_data = 32'h1; in_valid = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    @(negedge clk);
    chk("rx_exec_fs", {27'd0, alu_fs}, 32'h0C);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("rx_valid", {31'd0, out_valid}, 32'd0);
    chk("rx_ready", {31'd0, in_ready}, 32'd0);
    chk("rx_alu_fs", {27'd0, alu_fs}, 32'h13);
    chk("rx_alu_t", alu_t, 32'd0);
    chk("rx_wb_data", wb_data, 32'd0);
    chk("rx_flags", {28'd0, flags}, 32'h0);
    chk("rx_wb_en", {31'd0, wb_en}, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("rx_ready_after", {31'd0, in_ready}, 32'd1);
    seen = 1'b0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      seen = seen | out_valid;
    end
    chk("rx_no_record", {31'd0, seen}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/alu_issue_ctrl.md
# alu_issue_ctrl

Sequential issue/decode controller that drives the 32-bit combinational MIPS ALU from the other side of its interface. It accepts one MIPS R/I-type ALU instruction with its register operands over a valid/ready handshake, decodes it into the ALU function select and operands, and iterates the ALU's 1-bit shifts for multi-bit shift amounts. It captures the result and flags, then presents a writeback record over a second valid/ready handshake. It sits between register-file read and register-file writeback in the datapath.

## Interface
- No parameters; all widths fixed at 32-bit data, 5-bit FS, 5-bit register index.
- clk  in  1  sole clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high.
- in_valid  in  1  instruction/operands valid.
- in_ready  out  1  controller can accept; high only in IDLE and not in reset.
- instr  in  32  MIPS instruction word.
- rs_data, rt_data  in  32  register operands.
- alu_fs  out  5  function select to ALU.
- alu_s, alu_t  out  32  ALU operands.
- alu_n, alu_z, alu_v, alu_c  in  1  ALU flags.
- alu_y_lo  in  32  ALU result.
- out_valid  out  1  writeback record valid.
- out_ready  in  1  consumer accepts record.
- wb_data  out  32  result.
- wb_reg  out  5  destination register.
- wb_en  out  1  write enable (0 on $zero dest, illegal, or overflow trap).
- flags  out  4  {N,Z,V,C} of final ALU cycle, masked per Operation.
- illegal  out  1  undecodable instruction.
- ovf_trap  out  1  signed overflow on add/sub/addi.

## Operation
- FSM states: IDLE, EXEC, DONE.
- IDLE: in_ready=1. On in_valid, latch instr, rs_data→S reg, rt_data/immediate→T reg, decoded FS, dest, and cnt. Go to EXEC, or to DONE if illegal.
- R-type (opcode 0), funct→FS: 20 add→02, 21 addu→04, 22 sub→03, 23 subu→05, 24 and→08, 25 or→09, 26 xor→0A, 27 nor→0B, 2A slt→06, 2B sltu→07, 00 sll→0C, 02 srl→0D, 03 sra→0E. Dest = rd.
- I-type opcode→FS, T: 08 addi→02, sign-extended; 09 addiu→04, sign-extended; 0A slti→06, sign-extended; 0B sltiu→07, sign-extended; 0C andi→16; 0D ori→17; 0E xori→19; 0F lui→18. For 16/17/19/18, T = raw instr with the ALU using T[15:0]. Dest = rt.
- Any other opcode or funct: illegal=1, wb_en=0, wb_data=0, flags=0.
- Shifts: operand is rt_data in T; cnt = shamt. shamt=0 issues FS=01 (pass T) for one cycle.
- EXEC: alu_fs/alu_s/alu_t driven from registers. Each EXEC cycle latches alu_y_lo and flags. For shifts with cnt>1, T reg <= alu_y_lo and cnt--, staying in EXEC; otherwise go to DONE.
- Flag masking:
  - V kept only for FS 02/03/04/05; otherwise 0.
  - C kept for 02–05 and shifts; otherwise 0.
  - N and Z are always kept.
- ovf_trap = V for FS 02/03 only. When ovf_trap=1, wb_en=0.
- wb_en = 0 when dest = 0.
- DONE: out_valid=1. All out_* fields are held stable until out_valid & out_ready, then the FSM returns to IDLE.
- alu_fs = 13 (ZEROS), alu_s = alu_t = 0 in IDLE and DONE.

## Timing
- Reset: state=IDLE. in_ready=0 during reset and 1 the cycle after. out_valid=0, wb_*=0, flags=0, illegal=0, ovf_trap=0, alu_fs=13, alu_s=alu_t=0.
- Handshake accepted at edge 0. EXEC occupies cycles 1..n, where n = max(1, shamt) for shifts and 1 otherwise. out_valid rises at cycle n+1. Illegal instructions: out_valid at cycle 1.
- Minimum initiation interval is 3 cycles (IDLE→EXEC→DONE→IDLE). There is no overlap: in_ready=0 outside IDLE.
- out_ready low holds DONE indefinitely with outputs unchanged.
- in_valid while not ready is ignored and must be held by the producer.
- Reset asserted in any state wins over everything: the in-flight instruction is discarded and no record is emitted.

## Test plan
- add, rs=7FFFFFFF, rt=00000001, rd=3 -> wb_data=80000000, flags=1010, ovf_trap=1, wb_en=0, out_valid at cycle 2.
- sll shamt=4, rt=0000000F, rd=5 -> 4 EXEC cycles; out_valid at cycle 5; wb_data=000000F0, wb_en=1. sra shamt=31, rt=80000000 -> FFFFFFFF, N=1, C=0. sll shamt=0 -> passes rt unchanged in 1 cycle.
- addi rs=00000005, imm=FFFF, rt=2 -> wb_data=00000004, V=0. lui imm=1234 -> 12340000. andi rs=FFFFFFFF, imm=00F0 -> 000000F0. sltiu rs=1, imm=FFFF -> 1.
- Opcode 23 (lw) -> illegal=1, wb_en=0, out_valid at cycle 1. or with rd=0 -> wb_en=0, wb_data still computed.
- out_ready low 3 cycles in DONE -> outputs stable, in_ready=0, next in_valid ignored until the record is accepted.
- Reset asserted at EXEC cycle 2 of an sll shamt=10 -> next cycle IDLE with all reset values, and no out_valid pulse.
